// File: rtl/hazard_ctl.sv
// Pipeline hazard/stall sequencer: reset drain, load-use bubble, redirect flush,
// memory freeze, plus saturating stall/flush performance counters.
module hazard_ctl #(
    parameter int RESET_FLUSH = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwen,
    input  logic             ex_is_load,
    input  logic             ex_pc_sel,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LU   = 2'd2;
    localparam logic [1:0] S_MW   = 2'd3;

    localparam int DW = (RESET_FLUSH > 1) ? $clog2(RESET_FLUSH) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(RESET_FLUSH - 1);

    logic [1:0]       state, state_nxt;
    logic [DW-1:0]    drain;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             memstall, loaduse, redirect;

    assign memstall = (((state == S_RUN) || (state == S_LU)) && mem_req && !mem_ready)
                    || ((state == S_MW) && !mem_ready);

    // The bubble cycle masks the hazard so a held EX load cannot stall twice in a row.
    assign loaduse = ex_is_load && ex_regwen && (ex_rd != 5'd0) && (state != S_LU)
                  && ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        redirect     = 1'b0;
        state_nxt    = S_RUN;
        if (rst || (state == S_INIT)) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = (drain == '0) ? S_RUN : S_INIT;
        end else if (memstall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            state_nxt    = S_MW;
        end else if (ex_pc_sel) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect    = 1'b1;
            state_nxt   = S_RUN;
        end else if (loaduse) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = S_LU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            drain     <= DRAIN_INIT;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_INIT) && (drain != '0))
                drain <= drain - DW'(1);
            if (pc_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Counters read as zero for the whole reset window, not just after the first edge.
    assign stall_cycles = rst ? '0 : stall_cnt;
    assign flush_events = rst ? '0 : flush_cnt;

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard and stall sequencer for the rv32 pipeline. It sits beside the decode and execute control stages and produces the per-stage stall and flush strobes that sequence the whole datapath:
- reset drain of the front end;
- load-use bubble insertion;
- branch/jump redirect flush;
- full-pipeline freeze while a data-memory access is outstanding.

It also keeps two saturating performance counters.

## Interface
Parameters:
- RESET_FLUSH, 2, cycles the front end is flushed after reset release (≥1)
- CNT_W, 32, performance counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- ex_rd  in  5  destination of instruction in EX
- ex_regwen  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_pc_sel  in  1  EX resolved taken branch/jump (redirect)
- mem_req  in  1  MEM stage issued a data-memory access this cycle
- mem_ready  in  1  data-memory access complete (single-cycle pulse permitted)
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_stall  out  1  hold ID/EX register
- id_ex_flush  out  1  clear ID/EX to bubble
- ex_mem_stall  out  1  hold EX/MEM and suppress MEM writeback
- stall_cycles  out  CNT_W  cycles with pc_stall=1 since reset
- flush_events  out  CNT_W  redirect flushes since reset

## Operation
- State: INIT, RUN, LU_BUBBLE, MEM_WAIT (2-bit), plus drain counter.
- Outputs are combinational from state and current inputs; state and counters are registered.
- Conditions:
  - memstall = (RUN or LU_BUBBLE) and mem_req and !mem_ready, or MEM_WAIT and !mem_ready.
  - loaduse = ex_is_load & ex_regwen & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)); masked in LU_BUBBLE.
- Decision priority each cycle:
  - INIT:
    - pc_stall=1, if_id_flush=1, id_ex_flush=1, all others 0.
    - Counter loads RESET_FLUSH-1 on reset and decrements.
    - At 0 → RUN.
  - memstall:
    - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; flushes 0.
    - Next state MEM_WAIT.
    - Redirect and loaduse are ignored; EX is frozen, so they re-evaluate on release.
  - ex_pc_sel:
    - if_id_flush=1, id_ex_flush=1, pc_stall=0.
    - Next state RUN.
    - Redirect overrides loaduse because the ID instruction is wrong-path.
  - loaduse:
    - pc_stall=1, if_id_stall=1, id_ex_flush=1.
    - Next state LU_BUBBLE.
  - Otherwise: all strobes 0; next state RUN.
- MEM_WAIT holds the freeze until mem_ready is seen, even if mem_req drops. In the mem_ready cycle, the freeze releases and the remaining priorities are applied as in RUN.
- A stall strobe and a flush strobe for the same register are never both 1.
- Counters:
  - stall_cycles increments when pc_stall=1, including in INIT.
  - flush_events increments when the ex_pc_sel rule fires.
  - Both saturate at 2^CNT_W−1 with no wrap.

## Timing
- While rst=1 at an edge: state←INIT, counters←0. Outputs during rst: pc_stall=1, if_id_flush=1, id_ex_flush=1, all others 0, stall_cycles=0, flush_events=0.
- Reset mid-operation (any state, including MEM_WAIT) takes effect on the same edge; pending waits are discarded.
- Drain: with RESET_FLUSH=N, the first N cycles after rst falls are INIT; RUN starts at cycle N.
- Load-use costs exactly 1 bubble cycle. A back-to-back load-use on the following ID instruction produces a second bubble only after a non-LU_BUBBLE cycle.
- Memory freeze latency: 0 cycles (same cycle as mem_req). Release happens in the mem_ready cycle.
- Redirect flush is 1 cycle, with no added stall.
- Counters update on the edge ending the cycle in which the condition held.

## Test plan
- Reset release with RESET_FLUSH=2: rst low at cycle 0 → pc_stall/if_id_flush/id_ex_flush=1 for cycles 0–1, all 0 at cycle 2, stall_cycles=2.
- Load-use: ex_is_load=1, ex_regwen=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 → 1 cycle of pc_stall=if_id_stall=id_ex_flush=1, then 0. Repeat with ex_rd=0 → no stall.
- Redirect plus load-use in the same cycle: ex_pc_sel=1 with hazard → if_id_flush=id_ex_flush=1, pc_stall=0, flush_events +1, next state RUN.
- Memory wait: mem_req=1 for 1 cycle, mem_ready pulses 3 cycles later → all four stalls=1 for 3 cycles, 0 on the mem_ready cycle, stall_cycles +3.
- Redirect during freeze: ex_pc_sel=1 throughout a 2-cycle memstall → no flush during freeze; flush fires on the release cycle; flush_events +1 only.
- Saturation with CNT_W=4: hold a memstall for 20 cycles → stall_cycles stops at 15. Reset asserted in MEM_WAIT → outputs take reset values, state INIT.
